// File: rtl/mem_reinit_ctrl_if.sv
// rtl/mem_reinit_ctrl_if.sv - simple dual-port BRAM bus between reinit controller and memory
interface mem_reinit_ctrl_if #(
  parameter int ADDR_W  = 12,
  parameter int WID_MEM = 18
);
  logic [ADDR_W-1:0]  waddr;
  logic [WID_MEM-1:0] din;
  logic               we;
  logic [ADDR_W-1:0]  raddr;
  logic [WID_MEM-1:0] dout;

  modport master (output waddr, output din, output we, output raddr, input dout);
  modport slave  (input waddr, input din, input we, input raddr, output dout);
endinterface

// File: rtl/mem_reinit_ctrl.sv
// rtl/mem_reinit_ctrl.sv - in-place BRAM re-initialise and read-back checker
module mem_reinit_ctrl #(
  parameter int WID_MEM   = 18,
  parameter int DEPTH_MEM = 4096,
  parameter int ADDR_W    = 12,
  parameter int RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          pattern_sel,
  mem_reinit_ctrl_if.master   mem,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
  localparam int                DCW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DCW-1:0]    LAST_DRN  = DCW'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [DCW-1:0]     drain_cnt;
  logic [1:0]         sel_q;
  logic               pv [RD_LAT];
  logic [ADDR_W-1:0]  pa [RD_LAT];
  logic [WID_MEM-1:0] pe [RD_LAT];
  logic               mismatch;
  logic [ADDR_W:0]    err_nxt;
  logic               finishing;

  // Word written (and later expected) at address a for the latched pattern.
  function automatic logic [WID_MEM-1:0] pattern(input logic [1:0] sel, input logic [ADDR_W-1:0] a);
    logic [WID_MEM-1:0]        p;
    logic [WID_MEM+ADDR_W-1:0] wide;
    p    = '0;
    wide = {{WID_MEM{1'b0}}, a};
    case (sel)
      2'd0: p = '0;
      2'd1: p = '1;
      2'd2: p = wide[WID_MEM-1:0];
      default: for (int i = 0; i < WID_MEM; i++) p[i] = i[0] ^ a[0];
    endcase
    return p;
  endfunction

  assign mismatch  = pv[RD_LAT-1] && (mem.dout != pe[RD_LAT-1]);
  assign err_nxt   = err_count + {{ADDR_W{1'b0}}, mismatch};
  assign finishing = (state == DRAIN) && (state_nxt == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and memory-port drive; ports sit at zero outside their sweep phase.
  always_comb begin
    state_nxt = state;
    mem.we    = 1'b0;
    mem.waddr = '0;
    mem.din   = '0;
    mem.raddr = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = WRITE;
      WRITE: begin
        mem.we    = 1'b1;
        mem.waddr = addr_cnt;
        mem.din   = pattern(sel_q, addr_cnt);
        if (addr_cnt == LAST_ADDR) state_nxt = READ;
      end
      READ: begin
        mem.raddr = addr_cnt;
        if (addr_cnt == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: if (drain_cnt == LAST_DRN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep counters, pattern latch and result bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_cnt       <= '0;
      drain_cnt      <= '0;
      sel_q          <= 2'd0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done      <= finishing;
      addr_cnt  <= ((state == WRITE || state == READ) && addr_cnt != LAST_ADDR) ?
                   addr_cnt + ADDR_W'(1) : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
      if (state == IDLE && start) begin
        sel_q          <= pattern_sel;
        err_count      <= '0;
        first_err_addr <= '0;
        pass           <= 1'b0;
      end else begin
        err_count <= err_nxt;
        if (mismatch && err_count == '0) first_err_addr <= pa[RD_LAT-1];
        if (finishing) pass <= (err_nxt == '0);
      end
    end
  end

  // Read-compare delay line: address and expected word travel alongside the memory latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
        pe[i] <= '0;
      end
    end else begin
      pv[0] <= (state == READ);
      pa[0] <= addr_cnt;
      pe[0] <= pattern(sel_q, addr_cnt);
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// tb/tb_mem_reinit_ctrl.sv - directed self-checking bench for mem_reinit_ctrl
module tb_mem_reinit_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, start_a, busy_a, done_a, pass_a, inject_a;
  logic [1:0]  sel_a;
  logic [12:0] err_a;
  logic [11:0] fea_a;
  logic        reset_b, start_b, busy_b, done_b, pass_b;
  logic [1:0]  sel_b;
  logic [12:0] err_b;
  logic [11:0] fea_b;

  mem_reinit_ctrl_if #(.ADDR_W(12), .WID_MEM(18)) mif_a ();
  mem_reinit_ctrl_if #(.ADDR_W(12), .WID_MEM(18)) mif_b ();

  mem_reinit_ctrl dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .pattern_sel(sel_a), .mem(mif_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_addr(fea_a)
  );

  mem_reinit_ctrl #(.WID_MEM(18), .DEPTH_MEM(16), .ADDR_W(12), .RD_LAT(2)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .pattern_sel(sel_b), .mem(mif_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_addr(fea_b)
  );

  // Memory A: 4096 words, read latency 1, read-first, optional bit-0 corruption at 5 and 9.
  logic [17:0] mem_a [4096];
  logic [17:0] rd_a;
  always @(posedge clk) begin
    if (mif_a.we) mem_a[mif_a.waddr] <= mif_a.din;
    rd_a <= mem_a[mif_a.raddr] ^ {17'b0, inject_a && (mif_a.raddr == 12'd5 || mif_a.raddr == 12'd9)};
  end
  assign mif_a.dout = rd_a;

  // Memory B: 16 words, read latency 2.
  logic [17:0] mem_b [16];
  logic [17:0] rd_b0, rd_b1;
  always @(posedge clk) begin
    if (mif_b.we) mem_b[mif_b.waddr[3:0]] <= mif_b.din;
    rd_b0 <= mem_b[mif_b.raddr[3:0]];
    rd_b1 <= rd_b0;
  end
  assign mif_b.dout = rd_b1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] exp_pat(input logic [1:0] s, input logic [11:0] a);
    case (s)
      2'd0:    return 18'h00000;
      2'd1:    return 18'h3FFFF;
      2'd2:    return {6'h00, a};
      default: return a[0] ? 18'h15555 : 18'h2AAAA;
    endcase
  endfunction

  task automatic kick_a(input logic [1:0] s);
    @(negedge clk);
    sel_a   = s;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  int          we_cnt, wr_bad, rd_bad, done_cnt, done_cyc, busy_bad;
  logic        busy1, pass1;
  logic [12:0] err1;

  // Observe DUT A for one sweep; cycle n counts edges after the start-sampling edge.
  task automatic watch_a(input logic [1:0] s, input bit extra, input bit restart, input int exp_cyc);
    we_cnt = 0; wr_bad = 0; rd_bad = 0; done_cnt = 0; done_cyc = -1; busy_bad = 0;
    for (int n = 1; n <= exp_cyc + 8; n++) begin
      @(negedge clk);
      if (n == 1) begin busy1 = busy_a; err1 = err_a; pass1 = pass_a; end
      if (mif_a.we === 1'b1) begin
        if (mif_a.waddr !== 12'(we_cnt) || mif_a.din !== exp_pat(s, 12'(we_cnt))) wr_bad++;
        we_cnt++;
      end
      if (n > 4096 && n <= 8192 && mif_a.raddr !== 12'(n - 4097)) rd_bad++;
      if (busy_a !== (n < exp_cyc)) busy_bad++;
      if (done_a === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      start_a = (extra && (n == 50 || n == 5000)) || (restart && done_a === 1'b1);
      if (extra) sel_a = 2'd0;
      if (restart && done_a === 1'b1) break;
    end
    if (!restart) start_a = 1'b0;
  endtask

  initial begin
    int db_cyc, db_cnt, db_bad, db_we;
    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    sel_a = 2'd0; sel_b = 2'd0; inject_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", mif_a.we, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fea", fea_a, 0);
    chk("rst_waddr", mif_a.waddr, 0);
    chk("rst_raddr", mif_a.raddr, 0);
    chk("rst_din", mif_a.din, 0);
    chk("rst_busy_b", busy_b, 0);
    reset_a = 1'b0; reset_b = 1'b0;

    // Zeros, ideal memory.
    kick_a(2'd0);
    watch_a(2'd0, 1'b0, 1'b0, 8194);
    chk("t1_done_cyc", done_cyc, 8194);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_we_cnt", we_cnt, 4096);
    chk("t1_wr_bad", wr_bad, 0);
    chk("t1_rd_bad", rd_bad, 0);
    chk("t1_busy_bad", busy_bad, 0);
    chk("t1_pass", pass_a, 1);
    chk("t1_err", err_a, 0);
    chk("t1_fea", fea_a, 0);

    // Address pattern with corrupted reads at 5 and 9.
    inject_a = 1'b1;
    kick_a(2'd2);
    watch_a(2'd2, 1'b0, 1'b0, 8194);
    chk("t2_done_cyc", done_cyc, 8194);
    chk("t2_wr_bad", wr_bad, 0);
    chk("t2_pass", pass_a, 0);
    chk("t2_err", err_a, 2);
    chk("t2_fea", fea_a, 5);
    inject_a = 1'b0;

    // Checkerboard on the short, latency-2 instance.
    @(negedge clk);
    sel_b = 2'd3; start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    db_cyc = -1; db_cnt = 0; db_bad = 0; db_we = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1)  chk("t3_din0", mif_b.din, 18'h2AAAA);
      if (n == 2)  chk("t3_din1", mif_b.din, 18'h15555);
      if (n == 16) chk("t3_waddr15", mif_b.waddr, 15);
      if (n == 17) chk("t3_we_off", mif_b.we, 0);
      if (n == 34) chk("t3_busy34", busy_b, 1);
      if (n == 35) chk("t3_busy35", busy_b, 0);
      if (mif_b.we === 1'b1) begin
        if (mif_b.din !== exp_pat(2'd3, 12'(db_we))) db_bad++;
        db_we++;
      end
      if (done_b === 1'b1) begin
        db_cnt++;
        if (db_cyc < 0) db_cyc = n;
      end
    end
    chk("t3_done_cyc", db_cyc, 35);
    chk("t3_done_cnt", db_cnt, 1);
    chk("t3_we_cnt", db_we, 16);
    chk("t3_wr_bad", db_bad, 0);
    chk("t3_pass", pass_b, 1);
    chk("t3_err", err_b, 0);

    // Extra start pulses in WRITE and READ must be ignored.
    kick_a(2'd1);
    watch_a(2'd1, 1'b1, 1'b0, 8194);
    chk("t4_done_cyc", done_cyc, 8194);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_we_cnt", we_cnt, 4096);
    chk("t4_wr_bad", wr_bad, 0);
    chk("t4_busy_bad", busy_bad, 0);
    chk("t4_pass", pass_a, 1);

    // Reset during WRITE aborts the sweep without done.
    kick_a(2'd3);
    for (int n = 1; n < 100; n++) @(negedge clk);
    @(negedge clk);
    chk("t5_we_pre", mif_a.we, 1);
    chk("t5_waddr_pre", mif_a.waddr, 99);
    reset_a = 1'b1;
    @(posedge clk);
    #1 reset_a = 1'b0;
    @(negedge clk);
    chk("t5_we", mif_a.we, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_err", err_a, 0);
    db_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (done_a === 1'b1) db_cnt++;
      @(negedge clk);
    end
    chk("t5_no_done", db_cnt, 0);
    kick_a(2'd3);
    watch_a(2'd3, 1'b0, 1'b0, 8194);
    chk("t5_done_cyc", done_cyc, 8194);
    chk("t5_wr_bad", wr_bad, 0);
    chk("t5_pass", pass_a, 1);

    // Start in the done cycle launches a new sweep immediately.
    inject_a = 1'b1;
    kick_a(2'd2);
    watch_a(2'd2, 1'b0, 1'b1, 8194);
    chk("t6_done_cyc", done_cyc, 8194);
    chk("t6_err_prev", err_a, 2);
    chk("t6_pass_prev", pass_a, 0);
    inject_a = 1'b0;
    sel_a = 2'd0;
    @(posedge clk);
    #1 start_a = 1'b0;
    watch_a(2'd0, 1'b0, 1'b0, 8194);
    chk("t6_busy1", busy1, 1);
    chk("t6_err1", err1, 0);
    chk("t6_pass1", pass1, 0);
    chk("t6_done_cyc2", done_cyc, 8194);
    chk("t6_wr_bad", wr_bad, 0);
    chk("t6_pass", pass_a, 1);
    chk("t6_err", err_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
